// File: rtl/dcpu16_marb_if.sv
// Bus bundle for the two-requester memory arbiter: F and G request buses,
// the shared memory port, and the grant indicator.
interface dcpu16_marb_if;
  logic [15:0] f_adr, f_dto, f_dti;
  logic        f_stb, f_wre, f_ack;
  logic [15:0] g_adr, g_dto, g_dti;
  logic        g_stb, g_wre, g_ack;
  logic [15:0] m_adr, m_dto, m_dti;
  logic        m_stb, m_wre, m_ack;
  logic [1:0]  gnt;

  // Arbiter side
  modport slave (
    input  f_adr, f_dto, f_stb, f_wre,
    output f_dti, f_ack,
    input  g_adr, g_dto, g_stb, g_wre,
    output g_dti, g_ack,
    output m_adr, m_dto, m_stb, m_wre,
    input  m_dti, m_ack,
    output gnt
  );

  // Requester / memory environment side
  modport master (
    output f_adr, f_dto, f_stb, f_wre,
    input  f_dti, f_ack,
    output g_adr, g_dto, g_stb, g_wre,
    input  g_dti, g_ack,
    input  m_adr, m_dto, m_stb, m_wre,
    output m_dti, m_ack,
    input  gnt
  );
endinterface

// File: rtl/dcpu16_marb.sv
// Non-preemptive two-bus (F/G) arbiter in front of one shared memory port.
// Define DCPU16_MARB_RR_EN for round-robin tie-breaking; default is F-priority.
module dcpu16_marb (
  input logic           clk,
  input logic           rst,
  dcpu16_marb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_G = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_F    = 2'b01;
  localparam logic [1:0] GNT_G    = 2'b10;

  state_t      state;
  logic [15:0] m_adr_q, m_dto_q;
  logic        m_stb_q, m_wre_q;
  logic [1:0]  gnt_q;
  logic        pick_f;
  logic        any_req;

  assign any_req = bus.f_stb | bus.g_stb;

`ifdef DCPU16_MARB_RR_EN
  logic last_g;

  // On a tie the bus that was not granted last wins.
  assign pick_f = bus.f_stb & (~bus.g_stb | last_g);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_g <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_g <= ~pick_f;
    end
  end
`else
  assign pick_f = bus.f_stb;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_adr_q <= '0;
      m_dto_q <= '0;
      m_wre_q <= 1'b0;
      m_stb_q <= 1'b0;
      gnt_q   <= GNT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            m_stb_q <= 1'b1;
            if (pick_f) begin
              state   <= BUSY_F;
              gnt_q   <= GNT_F;
              m_adr_q <= bus.f_adr;
              m_dto_q <= bus.f_dto;
              m_wre_q <= bus.f_wre;
            end else begin
              state   <= BUSY_G;
              gnt_q   <= GNT_G;
              m_adr_q <= bus.g_adr;
              m_dto_q <= bus.g_dto;
              m_wre_q <= bus.g_wre;
            end
          end
        end
        BUSY_F, BUSY_G: begin
          // Request fields stay frozen; only the memory ack ends the transfer.
          if (bus.m_ack) begin
            state   <= IDLE;
            m_stb_q <= 1'b0;
            gnt_q   <= GNT_NONE;
          end
        end
        default: begin
          state   <= IDLE;
          m_stb_q <= 1'b0;
          gnt_q   <= GNT_NONE;
        end
      endcase
    end
  end

  assign bus.m_adr = m_adr_q;
  assign bus.m_dto = m_dto_q;
  assign bus.m_wre = m_wre_q;
  assign bus.m_stb = m_stb_q;
  assign bus.gnt   = gnt_q;

  // An owner that dropped stb gets no ack and no data.
  assign bus.f_ack = ~rst & (state == BUSY_F) & bus.m_ack & bus.f_stb;
  assign bus.g_ack = ~rst & (state == BUSY_G) & bus.m_ack & bus.g_stb;
  assign bus.f_dti = bus.f_ack ? bus.m_dti : 16'h0000;
  assign bus.g_dti = bus.g_ack ? bus.m_dti : 16'h0000;

endmodule

// File: tb/tb_dcpu16_marb.sv
// Directed scoreboard bench for dcpu16_marb; expected grants are queued when a
// request is raised and popped when the memory request appears.
module tb_dcpu16_marb;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  dcpu16_marb_if bus ();

  dcpu16_marb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  gnt;
    logic [15:0] adr;
    logic [15:0] dto;
    logic        wre;
    logic        drop;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] gnt, input logic [15:0] adr,
                      input logic [15:0] dto, input logic wre, input logic drop);
    exp_t e;
    e.gnt = gnt; e.adr = adr; e.dto = dto; e.wre = wre; e.drop = drop;
    sb.push_back(e);
  endtask

  // Waits for the next memory request, checks it against the scoreboard head,
  // inserts 'waits' wait cycles, acks with rdata and checks the return path.
  task automatic run_xfer(input int waits, input logic [15:0] rdata);
    exp_t e;
    int   n;
    logic own_f;
    logic acked;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.m_stb && n < 50);
    check("m_stb_rise", 32'(bus.m_stb), 32'd1);
    check("sb_entry", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e     = sb.pop_front();
    own_f = (e.gnt == 2'b01);
    acked = ~e.drop;
    check("gnt", 32'(bus.gnt), 32'(e.gnt));
    check("m_adr", 32'(bus.m_adr), 32'(e.adr));
    check("m_dto", 32'(bus.m_dto), 32'(e.dto));
    check("m_wre", 32'(bus.m_wre), 32'(e.wre));
    for (int i = 0; i < waits; i++) begin
      if (e.drop && i == 0) begin
        if (own_f) bus.f_stb = 1'b0;
        else       bus.g_stb = 1'b0;
        #1;
      end
      check("f_ack_wait", 32'(bus.f_ack), 32'd0);
      check("g_ack_wait", 32'(bus.g_ack), 32'd0);
      @(negedge clk); #1;
      check("m_stb_hold", 32'(bus.m_stb), 32'd1);
      check("m_adr_hold", 32'(bus.m_adr), 32'(e.adr));
      check("m_dto_hold", 32'(bus.m_dto), 32'(e.dto));
      check("m_wre_hold", 32'(bus.m_wre), 32'(e.wre));
      check("gnt_hold", 32'(bus.gnt), 32'(e.gnt));
    end
    bus.m_dti = rdata;
    bus.m_ack = 1'b1;
    #1;
    check("f_ack", 32'(bus.f_ack), 32'(own_f & acked));
    check("g_ack", 32'(bus.g_ack), 32'(~own_f & acked));
    check("f_dti", 32'(bus.f_dti), (own_f && acked)  ? 32'(rdata) : 32'd0);
    check("g_dti", 32'(bus.g_dti), (!own_f && acked) ? 32'(rdata) : 32'd0);
    @(negedge clk);
    bus.m_ack = 1'b0;
    bus.m_dti = 16'hDEAD;
    #1;
    check("idle_m_stb", 32'(bus.m_stb), 32'd0);
    check("idle_gnt", 32'(bus.gnt), 32'd0);
    check("idle_f_ack", 32'(bus.f_ack), 32'd0);
    check("idle_g_ack", 32'(bus.g_ack), 32'd0);
    check("idle_f_dti", 32'(bus.f_dti), 32'd0);
    check("idle_g_dti", 32'(bus.g_dti), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    bus.f_adr = '0; bus.f_dto = '0; bus.f_wre = 1'b0; bus.f_stb = 1'b1;
    bus.g_adr = '0; bus.g_dto = '0; bus.g_wre = 1'b0; bus.g_stb = 1'b1;
    bus.m_dti = 16'hDEAD; bus.m_ack = 1'b1;

    // Reset with requests and a memory ack present: nothing may be acked.
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_stb", 32'(bus.m_stb), 32'd0);
    check("rst_m_wre", 32'(bus.m_wre), 32'd0);
    check("rst_m_adr", 32'(bus.m_adr), 32'd0);
    check("rst_m_dto", 32'(bus.m_dto), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_f_ack", 32'(bus.f_ack), 32'd0);
    check("rst_g_ack", 32'(bus.g_ack), 32'd0);
    rst = 1'b0; bus.f_stb = 1'b0; bus.g_stb = 1'b0; bus.m_ack = 1'b0;

    // F read alone, memory acks one cycle after m_stb.
    bus.f_adr = 16'h1234; bus.f_dto = 16'h0000; bus.f_wre = 1'b0; bus.f_stb = 1'b1;
    push(2'b01, 16'h1234, 16'h0000, 1'b0, 1'b0);
    run_xfer(1, 16'hBEEF);
    bus.f_stb = 1'b0;

    // G write with three wait cycles.
    bus.g_adr = 16'hFFFF; bus.g_dto = 16'h00A5; bus.g_wre = 1'b1; bus.g_stb = 1'b1;
    push(2'b10, 16'hFFFF, 16'h00A5, 1'b1, 1'b0);
    run_xfer(3, 16'h5A5A);
    bus.g_stb = 1'b0; bus.g_wre = 1'b0;

    // Both requesters held, zero-wait memory.
    bus.f_adr = 16'hA000; bus.f_dto = 16'h1111; bus.f_wre = 1'b1;
    bus.g_adr = 16'hB000; bus.g_dto = 16'h2222; bus.g_wre = 1'b0;
    bus.f_stb = 1'b1; bus.g_stb = 1'b1;
`ifdef DCPU16_MARB_RR_EN
    push(2'b01, 16'hA000, 16'h1111, 1'b1, 1'b0);
    push(2'b10, 16'hB000, 16'h2222, 1'b0, 1'b0);
    push(2'b01, 16'hA000, 16'h1111, 1'b1, 1'b0);
    push(2'b10, 16'hB000, 16'h2222, 1'b0, 1'b0);
`else
    for (int i = 0; i < 4; i++) push(2'b01, 16'hA000, 16'h1111, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 4; i++) run_xfer(0, 16'hC000 + 16'(i));
    bus.f_stb = 1'b0; bus.g_stb = 1'b0;

    // F wins, drops stb mid-transfer; G, held meanwhile, is served next.
    bus.f_adr = 16'h3000; bus.f_dto = 16'h0000; bus.f_wre = 1'b0;
    bus.g_adr = 16'h4000; bus.g_dto = 16'h0042; bus.g_wre = 1'b1;
    bus.f_stb = 1'b1; bus.g_stb = 1'b1;
    push(2'b01, 16'h3000, 16'h0000, 1'b0, 1'b1);
    push(2'b10, 16'h4000, 16'h0042, 1'b1, 1'b0);
    run_xfer(2, 16'h7777);
    run_xfer(0, 16'h8888);
    bus.g_stb = 1'b0; bus.g_wre = 1'b0;

    // Reset in the middle of a G transfer that memory never acks.
    bus.g_adr = 16'h5000; bus.g_stb = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.m_stb && n < 50);
    check("busy_g_gnt", 32'(bus.gnt), 32'd2);
    check("busy_g_m_adr", 32'(bus.m_adr), 32'h5000);
    rst = 1'b1; bus.m_ack = 1'b1; bus.m_dti = 16'h1357;
    #1;
    check("rst_busy_g_ack", 32'(bus.g_ack), 32'd0);
    @(negedge clk); #1;
    check("post_rst_m_stb", 32'(bus.m_stb), 32'd0);
    check("post_rst_gnt", 32'(bus.gnt), 32'd0);
    check("post_rst_m_adr", 32'(bus.m_adr), 32'd0);
    check("post_rst_g_ack", 32'(bus.g_ack), 32'd0);
    rst = 1'b0; bus.g_stb = 1'b0;
    #1;
    check("stale_ack_f", 32'(bus.f_ack), 32'd0);
    check("stale_ack_g", 32'(bus.g_ack), 32'd0);
    @(negedge clk);
    bus.m_ack = 1'b0;
    #1;
    check("stale_ack_m_stb", 32'(bus.m_stb), 32'd0);
    check("stale_ack_gnt", 32'(bus.gnt), 32'd0);

    // First tie after reset goes to F.
    bus.f_adr = 16'h6000; bus.f_dto = 16'h0000; bus.f_wre = 1'b0;
    bus.f_stb = 1'b1; bus.g_stb = 1'b1;
    push(2'b01, 16'h6000, 16'h0000, 1'b0, 1'b0);
    run_xfer(0, 16'h2468);
    bus.f_stb = 1'b0; bus.g_stb = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("final_m_stb", 32'(bus.m_stb), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcpu16_marb.md
DCPU16_MARB -- requirements
Module: dcpu16_marb

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have ports f_adr/f_dto, input, 16 each, F-bus address and write data.
REQ-004 SHALL have ports f_stb/f_wre, input, 1 each, F-bus strobe and write enable.
REQ-005 SHALL have ports f_dti, output, 16, F-bus read data; f_ack, output, 1, F-bus acknowledge.
REQ-006 SHALL have ports g_adr/g_dto, input, 16 each; g_stb/g_wre, input, 1 each; G-bus request, same meaning as the F-bus ports.
REQ-007 SHALL have ports g_dti, output, 16; g_ack, output, 1; G-bus return, same meaning as the F-bus ports.
REQ-008 SHALL have ports m_adr/m_dto, output, 16 each; m_stb/m_wre, output, 1 each; shared memory request, registered.
REQ-009 SHALL have ports m_dti, input, 16; m_ack, input, 1; shared memory return.
REQ-010 SHALL have port gnt, output, 2, current owner: 00 none, 01 F, 10 G.

Function
REQ-011 SHALL use an FSM with states IDLE, BUSY_F and BUSY_G.
REQ-012 In IDLE with any stb high, SHALL select a winner and latch its adr/dto/wre into m_adr/m_dto/m_wre.
- SHALL assert m_stb and set gnt on the next edge.
- SHALL enter BUSY_F or BUSY_G.
REQ-013 In IDLE with both stb low, SHALL hold m_stb=0, gnt=00, and leave m_adr/m_dto/m_wre unchanged.
REQ-014 In BUSY_x, SHALL hold m_adr/m_dto/m_wre/m_stb stable until m_ack=1.
REQ-015 In the BUSY_x cycle where m_ack=1, the owner's ack SHALL be asserted combinationally, equal to m_ack & x_stb.
- x_dti SHALL equal m_dti in that same cycle.
REQ-016 On m_ack in BUSY_x, SHALL go to IDLE, deassert m_stb and clear gnt on the next edge.
- No back-to-back issue: one IDLE cycle between transfers.
REQ-017 The non-owner's ack SHALL stay 0 at all times.
- The non-owner's dti SHALL be 16'h0000.
- In IDLE, f_dti and g_dti SHALL be 16'h0000.
REQ-018 Minimum latency SHALL be: stb sampled at edge N, m_stb high in cycle N+1, x_ack in cycle N+1 if memory acks same-cycle.
REQ-019 A requester SHALL hold stb, adr, dto and wre stable until its ack; the arbiter does not re-sample them in BUSY.
REQ-020 If the owner drops stb before m_ack, the memory cycle SHALL complete, x_ack SHALL stay 0, and the data SHALL be discarded.
REQ-021 Both stb rising in the same IDLE cycle SHALL be resolved per REQ-026/027; the loser waits in IDLE with stb held.
REQ-022 Arbitration SHALL be non-preemptive; a request arriving during BUSY is considered only on return to IDLE.

Reset
REQ-023 On rst=1 at an edge, SHALL go to state IDLE regardless of current state, including mid-transfer.
- Outputs: m_stb=0, m_wre=0, m_adr=16'h0000, m_dto=16'h0000, gnt=00.
- Round-robin pointer SHALL be cleared to "last=G", so F wins the first tie.
REQ-024 A memory ack arriving in the cycle after reset SHALL be ignored (state IDLE).
REQ-025 While rst=1, f_ack and g_ack SHALL both be 0.

Configuration
REQ-026 With DCPU16_MARB_RR_EN defined, ties SHALL be round-robin.
- A 1-bit pointer records the last granted bus and updates on each grant.
- On a tie, the bus not last granted SHALL win.
REQ-027 Without DCPU16_MARB_RR_EN, ties SHALL be fixed priority with F always winning; no pointer flop SHALL exist.

Verification
REQ-028 Reset mid-BUSY_G (m_stb=1, m_ack never) -> next cycle: m_stb=0, gnt=00, g_ack=0; then f_stb -> F granted first.
REQ-029 F read alone: f_adr=16'h1234, f_stb=1, memory acks with m_dti=16'hBEEF one cycle after m_stb -> m_adr=16'h1234, m_wre=0, f_ack pulse 1 cycle, f_dti=16'hBEEF, g_ack=0.
REQ-030 G write: g_adr=16'hFFFF, g_dto=16'h00A5, g_wre=1, m_ack after 3 wait cycles -> m_* stable for 4 cycles, g_ack in the m_ack cycle only, then IDLE.
REQ-031 Simultaneous f_stb and g_stb held, zero-wait memory.
- RR_EN: grant order F,G,F,G.
- Without RR_EN: F,F,F... while f_stb stays high.
REQ-032 F owner drops f_stb before m_ack: m_ack arrives 2 cycles later -> f_ack=0, arbiter returns to IDLE, pending g_stb then granted.
